// File: rtl/calc_core_param_if.sv
// Key-event and display bundle between the keypad decoder, the calculator core and the display driver.
interface calc_core_param_if #(
    parameter int DIGITS = 5
);
    localparam int W = 4 * DIGITS;

    logic         newkey;
    logic [4:0]   keycode;
    logic [W-1:0] value;
    logic         busy;
    logic         overflow;

    // Keypad side: issues key strobes, watches the display and status.
    modport master (
        output newkey,
        output keycode,
        input  value,
        input  busy,
        input  overflow
    );

    // Calculator core side.
    modport slave (
        input  newkey,
        input  keycode,
        output value,
        output busy,
        output overflow
    );
endinterface

// File: rtl/calc_core_param.sv
// Parametrised calculator core: digit entry, add/sub/mul with left-to-right
// chaining, squaring, sticky overflow, and a sequential shift-add multiplier.
module calc_core_param #(
    parameter int DIGITS = 5
) (
    input  logic               clock,
    input  logic               reset,
    calc_core_param_if.slave   bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(W);

    localparam logic [4:0] K_ADD = 5'b01001;
    localparam logic [4:0] K_SUB = 5'b01011;
    localparam logic [4:0] K_MUL = 5'b01010;
    localparam logic [4:0] K_EQ  = 5'b00100;
    localparam logic [4:0] K_SQR = 5'b00001;
    localparam logic [4:0] K_CE  = 5'b00010;
    localparam logic [4:0] K_AC  = 5'b01100;

    typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL} op_t;
    typedef enum logic       {M_IDLE, M_RUN}                   mstate_t;
    typedef enum logic [1:0] {D_EQ, D_CHAIN, D_SQR}            dest_t;

    // Add/subtract with the carry (or borrow) returned in the top bit.
    function automatic logic [W:0] alu(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            default: return '0;
        endcase
    endfunction

    // Control / architectural state
    logic [W-1:0]   x_q, x_d;
    logic [W-1:0]   y_q, y_d;
    op_t            op_q, op_d;
    logic           lwn_q, lwn_d;
    logic           ovf_q, ovf_d;
    mstate_t        ms_q, ms_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // Multiplier datapath
    dest_t          dest_q, dest_d;
    op_t            pend_q, pend_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] acc_q, acc_d;

    logic [2*W-1:0] acc_step;
    logic [W:0]     res;
    logic           clear;
    op_t            key_op;

    // Next-state: key decode, immediate arithmetic, and multiplier sequencing.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        op_d     = op_q;
        lwn_d    = lwn_q;
        ovf_d    = ovf_q;
        ms_d     = ms_q;
        cnt_d    = cnt_q;
        dest_d   = dest_q;
        pend_d   = pend_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;

        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        res      = alu(op_q, y_q, x_q);
        clear    = bus.newkey && (bus.keycode == K_AC);

        case (bus.keycode)
            K_ADD:   key_op = OP_ADD;
            K_SUB:   key_op = OP_SUB;
            K_MUL:   key_op = OP_MUL;
            default: key_op = OP_NONE;
        endcase

        if (clear) begin
            // AC wins in both states; a running multiply is abandoned.
            x_d   = '0;
            y_d   = '0;
            op_d  = OP_NONE;
            lwn_d = 1'b0;
            ovf_d = 1'b0;
            ms_d  = M_IDLE;
            cnt_d = '0;
        end else if (ms_q == M_RUN) begin
            // One shift-add step per cycle; keys other than AC are dropped.
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
                ms_d = M_IDLE;
                x_d  = acc_step[W-1:0];
                if (|acc_step[2*W-1:W]) ovf_d = 1'b1;
                case (dest_q)
                    D_EQ: begin
                        y_d  = '0;
                        op_d = OP_NONE;
                    end
                    D_CHAIN: begin
                        y_d  = acc_step[W-1:0];
                        op_d = pend_q;
                    end
                    default: ;
                endcase
            end
        end else if (bus.newkey) begin
            if (bus.keycode[4]) begin
                if (!lwn_q) begin
                    x_d   = {{(W-4){1'b0}}, bus.keycode[3:0]};
                    lwn_d = 1'b1;
                end else if (x_q[W-1:W-4] == 4'd0) begin
                    x_d   = {x_q[W-5:0], bus.keycode[3:0]};
                    lwn_d = 1'b1;
                end
            end else if (key_op != OP_NONE) begin
                lwn_d = 1'b0;
                if (op_q != OP_NONE && lwn_q) begin
                    if (op_q == OP_MUL) begin
                        ms_d     = M_RUN;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = {{W{1'b0}}, y_q};
                        mplier_d = x_q;
                        dest_d   = D_CHAIN;
                        pend_d   = key_op;
                    end else begin
                        x_d  = res[W-1:0];
                        y_d  = res[W-1:0];
                        op_d = key_op;
                        if (res[W]) ovf_d = 1'b1;
                    end
                end else begin
                    y_d  = x_q;
                    op_d = key_op;
                end
            end else if (bus.keycode == K_EQ) begin
                lwn_d = 1'b0;
                if (op_q == OP_MUL) begin
                    ms_d     = M_RUN;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {{W{1'b0}}, y_q};
                    mplier_d = x_q;
                    dest_d   = D_EQ;
                end else if (op_q != OP_NONE) begin
                    x_d  = res[W-1:0];
                    y_d  = '0;
                    op_d = OP_NONE;
                    if (res[W]) ovf_d = 1'b1;
                end
            end else if (bus.keycode == K_SQR) begin
                lwn_d    = 1'b0;
                ms_d     = M_RUN;
                cnt_d    = '0;
                acc_d    = '0;
                mcand_d  = {{W{1'b0}}, x_q};
                mplier_d = x_q;
                dest_d   = D_SQR;
            end else if (bus.keycode == K_CE) begin
                x_d   = '0;
                ovf_d = 1'b0;
                lwn_d = 1'b0;
            end
        end
    end

    // Architectural and FSM state, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            op_q  <= OP_NONE;
            lwn_q <= 1'b0;
            ovf_q <= 1'b0;
            ms_q  <= M_IDLE;
            cnt_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            op_q  <= op_d;
            lwn_q <= lwn_d;
            ovf_q <= ovf_d;
            ms_q  <= ms_d;
            cnt_q <= cnt_d;
        end
    end

    // Multiplier operands and accumulator; always loaded before use.
    always_ff @(posedge clock) begin
        dest_q   <= dest_d;
        pend_q   <= pend_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        acc_q    <= acc_d;
    end

    assign bus.value    = x_q;
    assign bus.busy     = (ms_q == M_RUN);
    assign bus.overflow = ovf_q;
endmodule
